// File: rtl/uart_seq_pkg.sv
// uart_seq_pkg: command types, opcodes, frame counts and FSM states for uart_cmd_seq.
package uart_seq_pkg;
  typedef enum logic [1:0] {CMD_WR, CMD_RD, CMD_ALU_OP, CMD_ALU_NOP} cmd_type_e;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_GAP, SEQ_FRAME} seq_state_e;
  typedef enum logic [2:0] {SER_IDLE, SER_START, SER_DATA, SER_PARITY, SER_STOP} ser_state_e;
  localparam logic [7:0] OPC_WR      = 8'hAA;
  localparam logic [7:0] OPC_RD      = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;
  function automatic logic [2:0] frames_per_cmd(input cmd_type_e c);
    return c == CMD_WR ? 3'd3 : c == CMD_ALU_OP ? 3'd4 : 3'd2;
  endfunction
  function automatic logic [7:0] opcode(input cmd_type_e c);
    return c == CMD_WR ? OPC_WR : c == CMD_RD ? OPC_RD : c == CMD_ALU_OP ? OPC_ALU_OP : OPC_ALU_NOP;
  endfunction
endpackage

// File: rtl/uart_frame_ser.sv
// uart_frame_ser: serialises one frame (start, LSB-first data, optional parity, stop).
module uart_frame_ser
  import uart_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     payload,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic                      par_inv,
  input  logic                      last,
  output logic                      tx,
  output logic                      frame_done,
  output logic                      cmd_done
);
  localparam int BW = $clog2(DATA_WIDTH);
  ser_state_e                state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] timer_q, timer_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     sh_q, sh_d;
  logic                      par_q, par_d, pen_q, pen_d, last_q, last_d;
  logic                      tx_q, tx_d, fd_q, fd_d, cd_q, cd_d;
  logic                      tick;
  assign tick = timer_q == '0;
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pen_d   = pen_q;
    last_d  = last_q;
    timer_d = tick ? prescale - 1'b1 : timer_q - 1'b1;
    case (state_q)
      SER_IDLE: begin
        timer_d = prescale - 1'b1;
        if (start) begin
          state_d = SER_START;
          sh_d    = payload;
          par_d   = ^payload ^ par_typ ^ par_inv;
          pen_d   = par_en;
          last_d  = last;
        end
      end
      SER_START: if (tick) begin
        state_d = SER_DATA;
        bit_d   = '0;
      end
      SER_DATA: if (tick) begin
        sh_d  = sh_q >> 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DATA_WIDTH - 1)) state_d = pen_q ? SER_PARITY : SER_STOP;
      end
      SER_PARITY: if (tick) state_d = SER_STOP;
      SER_STOP:   if (tick) state_d = SER_IDLE;
      default:    state_d = SER_IDLE;
    endcase
    // Outputs are derived from the next state so they are registered yet aligned with it.
    tx_d = state_d == SER_START ? 1'b0 : state_d == SER_DATA ? sh_d[0] : state_d == SER_PARITY ? par_q : 1'b1;
    fd_d = state_d == SER_STOP && timer_d == '0;
    cd_d = fd_d && last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SER_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      last_q  <= 1'b0;
      tx_q    <= 1'b1;
      fd_q    <= 1'b0;
      cd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      fd_q    <= fd_d;
      cd_q    <= cd_d;
    end
  end
  assign tx         = tx_q;
  assign frame_done = fd_q;
  assign cmd_done   = cd_q;
endmodule

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: latches a command and sequences its UART frames with idle gaps (GAP_BITS >= 1).
// Define UART_SEQ_PAR_INJECT_EN to add INJ_PAR_ERR, which corrupts the last frame's parity bit.
module uart_cmd_seq
  import uart_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int GAP_BITS       = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic [1:0]                CMD_TYPE,
  input  logic [DATA_WIDTH-1:0]     ARG0,
  input  logic [DATA_WIDTH-1:0]     ARG1,
  input  logic [DATA_WIDTH-1:0]     ARG2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
`ifdef UART_SEQ_PAR_INJECT_EN
  input  logic                      INJ_PAR_ERR,
`endif
  output logic                      TX_OUT,
  output logic                      BUSY,
  output logic                      FRAME_DONE,
  output logic                      CMD_DONE
);
  localparam int GW = $clog2(GAP_BITS + 1);
  seq_state_e                seq_q, seq_d;
  cmd_type_e                 type_q, type_d;
  logic [PRESCALE_WIDTH-1:0] timer_q, timer_d, p_q, p_d, p_in;
  logic [GW-1:0]             gap_q, gap_d;
  logic [1:0]                frame_q, frame_d;
  logic [DATA_WIDTH-1:0]     a0_q, a0_d, a1_q, a1_d, a2_q, a2_d, payload;
  logic                      pen_q, pen_d, ptyp_q, ptyp_d, inj_q, inj_d, inj_in;
  logic                      ready_q, ready_d, busy_q, busy_d;
  logic                      accept, last_frame, gap_end;
`ifdef UART_SEQ_PAR_INJECT_EN
  assign inj_in = INJ_PAR_ERR;
`else
  assign inj_in = 1'b0;
`endif
  assign accept     = CMD_VALID && ready_q;
  assign p_in       = PRESCALE == '0 ? PRESCALE_WIDTH'(1) : PRESCALE;
  assign last_frame = 3'(frame_q) == frames_per_cmd(type_q) - 3'd1;
  assign gap_end    = seq_q == SEQ_GAP && timer_q == '0 && gap_q == GW'(GAP_BITS - 1);
  assign payload    = frame_q == 2'd0 ? DATA_WIDTH'(opcode(type_q)) :
                      frame_q == 2'd1 ? (type_q == CMD_ALU_NOP ? a2_q : a0_q) :
                      frame_q == 2'd2 ? a1_q : a2_q;
  always_comb begin
    seq_d   = seq_q;
    type_d  = type_q;
    timer_d = timer_q;
    p_d     = p_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    pen_d   = pen_q;
    ptyp_d  = ptyp_q;
    inj_d   = inj_q;
    case (seq_q)
      SEQ_IDLE: if (accept) begin
        seq_d   = SEQ_GAP;
        type_d  = cmd_type_e'(CMD_TYPE);
        timer_d = p_in - 1'b1;
        p_d     = p_in;
        gap_d   = '0;
        frame_d = '0;
        a0_d    = ARG0;
        a1_d    = ARG1;
        a2_d    = ARG2;
        pen_d   = PAR_EN;
        ptyp_d  = PAR_TYP;
        inj_d   = inj_in;
      end
      SEQ_GAP: begin
        timer_d = timer_q - 1'b1;
        if (timer_q == '0) begin
          timer_d = p_q - 1'b1;
          gap_d   = gap_q + 1'b1;
          if (gap_end) seq_d = SEQ_FRAME;
        end
      end
      SEQ_FRAME: if (FRAME_DONE) begin
        seq_d   = last_frame ? SEQ_IDLE : SEQ_GAP;
        timer_d = p_q - 1'b1;
        gap_d   = '0;
        frame_d = frame_q + 1'b1;
      end
      default: seq_d = SEQ_IDLE;
    endcase
    ready_d = seq_d == SEQ_IDLE;
    busy_d  = !ready_d;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      seq_q   <= SEQ_IDLE;
      type_q  <= CMD_WR;
      timer_q <= '0;
      p_q     <= '0;
      gap_q   <= '0;
      frame_q <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      inj_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      seq_q   <= seq_d;
      type_q  <= type_d;
      timer_q <= timer_d;
      p_q     <= p_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      pen_q   <= pen_d;
      ptyp_q  <= ptyp_d;
      inj_q   <= inj_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end
  uart_frame_ser #(
    .DATA_WIDTH    (DATA_WIDTH),
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_ser (
    .clk       (CLK),
    .rst_n     (RST),
    .start     (gap_end),
    .payload   (payload),
    .prescale  (p_q),
    .par_en    (pen_q),
    .par_typ   (ptyp_q),
    .par_inv   (inj_q && last_frame),
    .last      (last_frame),
    .tx        (TX_OUT),
    .frame_done(FRAME_DONE),
    .cmd_done  (CMD_DONE)
  );
  assign CMD_READY = ready_q;
  assign BUSY      = busy_q;
endmodule

// File: tb/tb_uart_cmd_seq.sv
// tb_uart_cmd_seq: directed checks of frame contents, timing, back-to-back, reset and prescale 0.
module tb_uart_cmd_seq;
  localparam int DW = 8, PW = 6, G = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, par_en = 1'b0, par_typ = 1'b0, inj_par = 1'b0;
  logic [1:0] cmd_type = 2'd0;
  logic [DW-1:0] arg0 = '0, arg1 = '0, arg2 = '0;
  logic [PW-1:0] prescale = '0;
  logic tx_out, busy, frame_done, cmd_done;
  always #5 clk = ~clk;
  uart_cmd_seq #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW), .GAP_BITS(G)) dut (
    .CLK(clk), .RST(rst_n), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_TYPE(cmd_type),
    .ARG0(arg0), .ARG1(arg1), .ARG2(arg2), .PRESCALE(prescale), .PAR_EN(par_en), .PAR_TYP(par_typ),
`ifdef UART_SEQ_PAR_INJECT_EN
    .INJ_PAR_ERR(inj_par),
`endif
    .TX_OUT(tx_out), .BUSY(busy), .FRAME_DONE(frame_done), .CMD_DONE(cmd_done));
  int vecs = 0, errs = 0;
  logic line [0:4095];
  int done_at, fd_cnt, busy_bad, hold_bad [4];
  logic [7:0] got_b [4];
  logic got_p [4], got_start [4], got_stop [4], got_gap [4];
  logic ready_after, busy_after;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_cmd(input logic [1:0] t, input logic [7:0] a0, a1, a2, input int p,
                         input logic pen, ptyp, inj, hold, input int nfr);
    int pe, f, base, s, pn;
    cmd_type = t; arg0 = a0; arg1 = a1; arg2 = a2; prescale = PW'(p);
    par_en = pen; par_typ = ptyp; inj_par = inj; cmd_valid = 1'b1;
    @(posedge clk);
    done_at = 0; fd_cnt = 0; busy_bad = 0;
    for (int n = 1; n <= 4000 && done_at == 0; n++) begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      line[n-1] = tx_out;
      if (frame_done) fd_cnt++;
      if (busy !== 1'b1) busy_bad++;
      if (cmd_done) done_at = n;
    end
    pe = p == 0 ? 1 : p;
    pn = int'(pen);
    f  = G + 1 + 8 + pn + 1;
    for (int i = 0; i < nfr; i++) begin
      base = i * f * pe;
      s = base + G * pe;
      hold_bad[i] = 0;
      for (int b = 0; b < f; b++)
        for (int c = 1; c < pe; c++)
          if (line[base+b*pe+c] !== line[base+b*pe]) hold_bad[i]++;
      got_gap[i] = line[base];
      got_start[i] = line[s];
      for (int j = 0; j < 8; j++) got_b[i][j] = line[s+(1+j)*pe];
      got_p[i] = line[s+9*pe];
      got_stop[i] = line[s+(9+pn)*pe];
    end
    @(negedge clk);
    ready_after = cmd_ready;
    busy_after = busy;
  endtask
  task automatic check_cmd(input string tag, input int nfr, input logic [31:0] eb, input logic [3:0] ep,
                           input logic pen, input int dur);
    chk({tag, ".cmd_done_cycle"}, done_at, dur);
    chk({tag, ".frame_done_cnt"}, fd_cnt, nfr);
    chk({tag, ".busy_low_cycles"}, busy_bad, 0);
    chk({tag, ".ready_after"}, ready_after, 1);
    chk({tag, ".busy_after"}, busy_after, 0);
    for (int i = 0; i < nfr; i++) begin
      chk($sformatf("%s.f%0d.byte", tag, i), got_b[i], eb[8*i+:8]);
      chk($sformatf("%s.f%0d.gap", tag, i), got_gap[i], 1);
      chk($sformatf("%s.f%0d.start", tag, i), got_start[i], 0);
      chk($sformatf("%s.f%0d.stop", tag, i), got_stop[i], 1);
      chk($sformatf("%s.f%0d.bit_hold", tag, i), hold_bad[i], 0);
      if (pen) chk($sformatf("%s.f%0d.parity", tag, i), got_p[i], ep[i]);
    end
  endtask
  initial begin
    int tog;
    repeat (2) @(negedge clk);
    chk("rst.tx", tx_out, 1);
    chk("rst.ready", cmd_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.cmd_done", cmd_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(2'd0, 8'h05, 8'hA6, 8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    check_cmd("wr_p4_even", 3, {8'h00, 8'hA6, 8'h05, 8'hAA}, 4'b0000, 1'b1, 144);
    run_cmd(2'd1, 8'h05, 8'h00, 8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    check_cmd("rd_p32_odd", 2, {16'h0, 8'h05, 8'hBB}, 4'b0011, 1'b1, 768);
    run_cmd(2'd2, 8'h03, 8'h04, 8'h01, 2, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    check_cmd("alu_p2_nopar", 4, {8'h01, 8'h04, 8'h03, 8'hCC}, 4'b0000, 1'b0, 88);
    run_cmd(2'd3, 8'h11, 8'h22, 8'h5A, 3, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    check_cmd("nop_p3_odd", 2, {16'h0, 8'h5A, 8'hDD}, 4'b0011, 1'b1, 72);
    run_cmd(2'd0, 8'h05, 8'hA6, 8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    check_cmd("b2b_wr", 3, {8'h00, 8'hA6, 8'h05, 8'hAA}, 4'b0000, 1'b1, 144);
    run_cmd(2'd1, 8'h05, 8'h00, 8'h00, 4, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    check_cmd("b2b_rd", 2, {16'h0, 8'h05, 8'hBB}, 4'b0011, 1'b1, 96);
    run_cmd(2'd1, 8'h05, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    check_cmd("rd_p0", 2, {16'h0, 8'h05, 8'hBB}, 4'b0000, 1'b1, 24);
    cmd_type = 2'd0; arg0 = 8'h05; arg1 = 8'hA6; prescale = PW'(4); par_en = 1'b1; par_typ = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_mid.line_before", tx_out, 0);
    chk("rst_mid.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.tx", tx_out, 1);
    chk("rst_mid.ready", cmd_ready, 1);
    chk("rst_mid.busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tog = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) tog++;
    end
    chk("rst_mid.quiet", tog, 0);
    run_cmd(2'd1, 8'h05, 8'h00, 8'h00, 4, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    check_cmd("after_rst_rd", 2, {16'h0, 8'h05, 8'hBB}, 4'b0000, 1'b1, 96);
`ifdef UART_SEQ_PAR_INJECT_EN
    run_cmd(2'd0, 8'h05, 8'hA6, 8'h00, 4, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    check_cmd("wr_inject", 3, {8'h00, 8'hA6, 8'h05, 8'hAA}, 4'b0100, 1'b1, 144);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
